// File: rtl/sort_serializer_if.sv
// Byte-stream bundle between the sort stage, the serializer and its downstream consumer.
//
// Handshake: the vector side (i_data/i_valid) has no ready; a vector is presented
// for exactly one cycle. On the byte side, a byte moves on every rising edge where
// o_valid && i_ready. Once o_valid is high it stays high, with o_data and o_last
// held, until that transfer happens.
interface sort_serializer_if #(
  parameter int N     = 4,
  parameter int DEPTH = 4
);
  logic [N-1:0][7:0]              i_data;
  logic                           i_valid;
  logic [7:0]                     o_data;
  logic                           o_valid;
  logic                           i_ready;
  logic                           o_last;
  logic [$clog2(DEPTH+1)-1:0]     o_level;
  logic                           o_overflow;

  // Producer/consumer side: supplies vectors and the downstream ready.
  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid, o_last, o_level, o_overflow
  );

  // Serializer side.
  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid, o_last, o_level, o_overflow
  );
endinterface

// File: rtl/sort_serializer.sv
// Buffers sorted N-byte vectors in a DEPTH-entry FIFO and streams them out one
// byte per cycle, flagging the last byte of each vector. Vectors arriving while
// the FIFO is full are dropped and recorded in a sticky overflow flag.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sort_serializer #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int ORDER = 0
) (
  input logic              i_clk,
  input logic              i_rst_n,
  sort_serializer_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [KW-1:0] K_LAST     = KW'(N - 1);

  logic [N-1:0][7:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [KW-1:0]     k;
  logic [LW-1:0]     level;
  logic              overflow;

  logic              full;
  logic              empty;
  logic              wr_en;
  logic              xfer;
  logic              pop;
  logic [N-1:0][7:0] head;
  logic [KW-1:0]     sel;
  logic [7:0]        byte_out;

  // Full/empty come from registered occupancy, so a write on the edge that pops
  // the last byte of a full FIFO is still refused.
  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);
  assign wr_en = bus.i_valid && !full;
  assign xfer  = !empty && bus.i_ready;
  assign pop   = xfer && (k == K_LAST);

  // Select the current byte of the head vector in the configured order.
  always_comb begin
    head = mem[rd_ptr];
    sel  = (ORDER == 0) ? k : (K_LAST - k);
    byte_out = empty ? 8'h00 : head[sel];
  end

  // Vector storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= bus.i_data;
  end

  // Pointers, byte index, occupancy and sticky overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      k        <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (bus.i_valid && full) overflow <= 1'b1;
      if (xfer) begin
        if (k == K_LAST) begin
          k      <= '0;
          rd_ptr <= rd_ptr + AW'(1);
        end else begin
          k <= k + KW'(1);
        end
      end
      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign bus.o_data     = byte_out;
  assign bus.o_valid    = !empty;
  assign bus.o_last     = !empty && (k == K_LAST);
  assign bus.o_level    = level;
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_sort_serializer.sv
// Directed bench for sort_serializer. Two instances (byte order 0 and 1) share
// the same stimulus; each has its own expected-byte queue filled when a vector
// is accepted and drained by a negedge monitor on every handshake.
module tb_sort_serializer;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic [N-1:0][7:0] i_data = '0;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int xfers0 = 0;
  int x0;

  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];

  sort_serializer_if #(.N(N), .DEPTH(DEPTH)) bus0 ();
  sort_serializer_if #(.N(N), .DEPTH(DEPTH)) bus1 ();

  assign bus0.i_data  = i_data;
  assign bus0.i_valid = i_valid;
  assign bus0.i_ready = i_ready;
  assign bus1.i_data  = i_data;
  assign bus1.i_valid = i_valid;
  assign bus1.i_ready = i_ready;

  sort_serializer #(.N(N), .DEPTH(DEPTH), .ORDER(0)) dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus0)
  );
  sort_serializer #(.N(N), .DEPTH(DEPTH), .ORDER(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus1)
  );

  // Clock.
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present one vector for a single edge; queue its bytes if it should be kept.
  task automatic write_vec(input logic [31:0] v, input bit accept);
    i_data  = v;
    i_valid = 1'b1;
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        exp0_q.push_back({(i == N - 1), v[i*8 +: 8]});
        exp1_q.push_back({(i == N - 1), v[(N-1-i)*8 +: 8]});
      end
    end
    step();
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    repeat (2) step();
    i_rst_n = 1'b1;
  endtask

  // Let the DUTs run until both scoreboards are empty, bounded.
  task automatic drain(input string tag);
    for (int c = 0; c < 200 && (exp0_q.size() != 0 || exp1_q.size() != 0); c++) step();
    check(tag, exp0_q.size() + exp1_q.size(), 0);
  endtask

  // Scoreboard: every handshake must match the head of the expected queue.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (bus0.o_valid && i_ready) begin
        xfers0++;
        if (exp0_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL dut0_spurious: observed=%0h expected=none", {bus0.o_last, bus0.o_data});
        end else begin
          check("dut0_byte", {23'd0, bus0.o_last, bus0.o_data}, {23'd0, exp0_q.pop_front()});
        end
      end
      if (bus1.o_valid && i_ready) begin
        if (exp1_q.size() == 0) begin
          checks++;
          fails++;
          $error("FAIL dut1_spurious: observed=%0h expected=none", {bus1.o_last, bus1.o_data});
        end else begin
          check("dut1_byte", {23'd0, bus1.o_last, bus1.o_data}, {23'd0, exp1_q.pop_front()});
        end
      end
    end
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (2) step();
    @(negedge i_clk);
    check("rst_valid", bus0.o_valid, 0);
    check("rst_last", bus0.o_last, 0);
    check("rst_data", bus0.o_data, 0);
    check("rst_level", bus0.o_level, 0);
    check("rst_overflow", bus0.o_overflow, 0);
    check("rst_valid1", bus1.o_valid, 0);
    step();
    i_rst_n = 1'b1;
    step();

    // Single vector, both byte orders, one byte per cycle right after the write.
    i_ready = 1'b1;
    write_vec(32'h10203040, 1'b1);
    for (int i = 0; i < N; i++) begin
      @(negedge i_clk);
      check("t1_valid", bus0.o_valid, 1);
      check("t1_level", bus0.o_level, 1);
      if (i == 0) begin
        check("t1_first0", bus0.o_data, 8'h40);
        check("t1_first1", bus1.o_data, 8'h10);
      end
      step();
    end
    @(negedge i_clk);
    check("t1_level_end", bus0.o_level, 0);
    check("t1_valid_end", bus0.o_valid, 0);
    check("t1_data_idle", bus0.o_data, 0);
    check("t1_queue", exp0_q.size() + exp1_q.size(), 0);

    // Stall: first byte held for 5 cycles, then delivered exactly once.
    step();
    i_ready = 1'b0;
    write_vec(32'hA4A3A2A1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      check("stall_valid", bus0.o_valid, 1);
      check("stall_last", bus0.o_last, 0);
      check("stall_data0", bus0.o_data, 8'hA1);
      check("stall_data1", bus1.o_data, 8'hA4);
      step();
    end
    i_ready = 1'b1;
    drain("stall_drain");
    @(negedge i_clk);
    check("stall_idle", bus0.o_valid, 0);

    // Overflow: five back-to-back vectors into a 4-deep FIFO with no ready.
    step();
    i_ready = 1'b0;
    x0 = xfers0;
    write_vec(32'h13121110, 1'b1);
    write_vec(32'h23222120, 1'b1);
    write_vec(32'h33323130, 1'b1);
    write_vec(32'h43424140, 1'b1);
    write_vec(32'h53525150, 1'b0);
    @(negedge i_clk);
    check("ovf_level", bus0.o_level, DEPTH);
    check("ovf_flag", bus0.o_overflow, 1);
    step();
    i_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_bytes", xfers0 - x0, 16);
    @(negedge i_clk);
    check("ovf_sticky", bus0.o_overflow, 1);
    check("ovf_level0", bus0.o_level, 0);

    // Write while full on the edge that pops the last byte: still dropped.
    step();
    do_reset();
    @(negedge i_clk);
    check("pf_ovf_clear", bus0.o_overflow, 0);
    step();
    i_ready = 1'b0;
    x0 = xfers0;
    write_vec(32'h63626160, 1'b1);
    write_vec(32'h73727170, 1'b1);
    write_vec(32'h83828180, 1'b1);
    write_vec(32'h93929190, 1'b1);
    i_ready = 1'b1;
    repeat (3) step();
    @(negedge i_clk);
    check("pf_last", bus0.o_last, 1);
    check("pf_level4", bus0.o_level, DEPTH);
    write_vec(32'hB3B2B1B0, 1'b0);
    @(negedge i_clk);
    check("pf_level3", bus0.o_level, 3);
    check("pf_ovf", bus0.o_overflow, 1);
    drain("pf_drain");
    check("pf_bytes", xfers0 - x0, 16);

    // Reset in the middle of a vector discards everything.
    step();
    write_vec(32'hC3C2C1C0, 1'b1);
    write_vec(32'hD3D2D1D0, 1'b1);
    step();
    i_rst_n = 1'b0;
    exp0_q.delete();
    exp1_q.delete();
    #1;
    check("mr_valid", bus0.o_valid, 0);
    check("mr_level", bus0.o_level, 0);
    check("mr_overflow", bus0.o_overflow, 0);
    repeat (2) step();
    i_rst_n = 1'b1;
    repeat (3) step();
    @(negedge i_clk);
    check("mr_quiet", bus0.o_valid, 0);
    check("mr_quiet1", bus1.o_valid, 0);
    step();
    write_vec(32'hE3E2E1E0, 1'b1);
    @(negedge i_clk);
    check("mr_first0", bus0.o_data, 8'hE0);
    check("mr_first1", bus1.o_data, 8'hE3);
    drain("mr_drain");
    @(negedge i_clk);
    check("mr_idle", bus0.o_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
